// File: rtl/main_memory.sv
// Word-addressed backing RAM with single-cycle writes and reads that complete
// after a fixed latency, signalled by a one-cycle done pulse.
module main_memory #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  mem_write,
  input  logic                  waring,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] read_value
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BUSY = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [ADDR_WIDTH-1:0] addr_q, addr_next;
  logic                  accept_c;
  logic [ADDR_WIDTH-1:0] rd_addr_c;

  // Contents survive rst; only the power-on value is zero.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  // Next-state logic; a write in the same cycle blocks read acceptance.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    addr_next  = addr_q;
    rd_addr_c  = addr_q;
    accept_c   = waring && !mem_write && ((state == IDLE) || (state == DONE));
    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
        if (accept_c) begin
          addr_next = address;
          rd_addr_c = address;
          if (READ_LATENCY <= 1) begin
            state_next = DONE;
          end else begin
            state_next = BUSY;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      BUSY: begin
        if (cnt == LAST_BUSY) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control registers; read data is sampled on the DONE entry edge (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      done       <= 1'b0;
      read_value <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      addr_q <= addr_next;
      done   <= (state_next == DONE);
      if (state_next == DONE) begin
        read_value <= mem[rd_addr_c];
      end
    end
  end

  // Write port, accepted in any state.
  always_ff @(posedge clk) begin
    if (!rst && mem_write) begin
      mem[address] <= data_in;
    end
  end

endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory: one instance at READ_LATENCY=1 and one at 4,
// sharing write/address/reset stimulus with separate read requests.
module tb_main_memory;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;

  logic          clk;
  logic          rst;
  logic [DW-1:0] data_in;
  logic [AW-1:0] address;
  logic          mem_write;
  logic          waring1, waring4;
  logic          done1, done4;
  logic [DW-1:0] read_value1, read_value4;

  int checks   = 0;
  int failures = 0;
  int done_cnt1 = 0;
  int done_cnt4 = 0;

  logic [DW-1:0] model [0:(1<<AW)-1];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] exp_q4[$];

  main_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .address(address),
    .mem_write(mem_write), .waring(waring1), .done(done1), .read_value(read_value1)
  );

  main_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .data_in(data_in), .address(address),
    .mem_write(mem_write), .waring(waring4), .done(done4), .read_value(read_value4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters: each posedge counts the done level of the cycle just ended.
  always @(posedge clk) begin
    if (done1) done_cnt1++;
    if (done4) done_cnt4++;
  end

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    address   = a;
    data_in   = d;
    mem_write = 1'b1;
    waring1   = 1'b0;
    waring4   = 1'b0;
    model[a]  = d;
  endtask

  task automatic read1(input logic [AW-1:0] a, input string name);
    logic [DW-1:0] exp;
    @(negedge clk);
    address   = a;
    mem_write = 1'b0;
    waring1   = 1'b1;
    exp_q1.push_back(model[a]);
    @(negedge clk);
    waring1 = 1'b0;
    exp = exp_q1.pop_front();
    checks++;
    if (done1 !== 1'b1 || read_value1 !== exp) begin
      failures++;
      $display("FAIL %s: done=%b read_value=%h, required done=1 read_value=%h",
               name, done1, read_value1, exp);
    end
  endtask

  task automatic read4_wait(input logic [AW-1:0] a, input string name);
    logic [DW-1:0] exp;
    bit got;
    got = 1'b0;
    @(negedge clk);
    address   = a;
    mem_write = 1'b0;
    waring4   = 1'b1;
    exp_q4.push_back(model[a]);
    @(negedge clk);
    waring4 = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (done4) got = 1'b1;
      else @(negedge clk);
    end
    exp = exp_q4.pop_front();
    checks++;
    if (!got || read_value4 !== exp) begin
      failures++;
      $display("FAIL %s: done_seen=%b read_value=%h, required done_seen=1 read_value=%h",
               name, got, read_value4, exp);
    end
  endtask

  task automatic test_reset();
    int c1, c4;
    rst = 1'b1; waring1 = 1'b1; waring4 = 1'b1; address = 10'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks += 2;
      if (done1 !== 1'b0 || read_value1 !== '0) begin
        failures++;
        $display("FAIL reset_l1: done=%b read_value=%h, required 0/0", done1, read_value1);
      end
      if (done4 !== 1'b0 || read_value4 !== '0) begin
        failures++;
        $display("FAIL reset_l4: done=%b read_value=%h, required 0/0", done4, read_value4);
      end
    end
    c1 = done_cnt1; c4 = done_cnt4;
    rst = 1'b0; waring1 = 1'b0; waring4 = 1'b0;
    settle(8);
    checks++;
    if (done_cnt1 != c1 || done_cnt4 != c4) begin
      failures++;
      $display("FAIL reset_release: done pulses l1=%0d l4=%0d, required 0/0",
               done_cnt1 - c1, done_cnt4 - c4);
    end
  endtask

  task automatic test_seq_writes();
    logic [AW-1:0] addrs [5];
    logic [DW-1:0] vals  [5];
    logic [AW-1:0] rd    [6];
    addrs = '{10'd0, 10'd1, 10'd3, 10'd4, 10'd5};
    vals  = '{32'd50, 32'd60, 32'd70, 32'd80, 32'd90};
    rd    = '{10'd3, 10'd0, 10'd1, 10'd4, 10'd5, 10'd2};
    for (int i = 0; i < 5; i++) write_word(addrs[i], vals[i]);
    for (int i = 0; i < 6; i++) read1(rd[i], $sformatf("seq_read_addr%0d", rd[i]));
  endtask

  task automatic test_latency();
    logic [DW-1:0] exp;
    @(negedge clk);
    address = 10'd5; mem_write = 1'b0; waring4 = 1'b1;
    exp_q4.push_back(model[5]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      waring4 = 1'b0;
      checks++;
      if (done4 !== 1'b0) begin
        failures++;
        $display("FAIL latency_early_%0d: done=%b, required 0", i, done4);
      end
    end
    @(negedge clk);
    exp = exp_q4.pop_front();
    checks++;
    if (done4 !== 1'b1 || read_value4 !== exp) begin
      failures++;
      $display("FAIL latency_done: done=%b read_value=%h, required 1/%h", done4, read_value4, exp);
    end
    @(negedge clk);
    checks++;
    if (done4 !== 1'b0 || read_value4 !== exp) begin
      failures++;
      $display("FAIL latency_hold: done=%b read_value=%h, required 0/%h", done4, read_value4, exp);
    end
  endtask

  task automatic test_collision();
    int c1, c4;
    settle(2);
    c1 = done_cnt1; c4 = done_cnt4;
    @(negedge clk);
    address = 10'd7; data_in = 32'hDEADBEEF; mem_write = 1'b1;
    waring1 = 1'b1; waring4 = 1'b1;
    model[7] = 32'hDEADBEEF;
    @(negedge clk);
    mem_write = 1'b0; waring1 = 1'b0; waring4 = 1'b0;
    settle(8);
    checks++;
    if (done_cnt1 != c1 || done_cnt4 != c4) begin
      failures++;
      $display("FAIL collision_no_done: pulses l1=%0d l4=%0d, required 0/0",
               done_cnt1 - c1, done_cnt4 - c4);
    end
    read1(10'd7, "collision_read_l1");
    read4_wait(10'd7, "collision_read_l4");
  endtask

  task automatic test_reset_mid_read();
    int c4;
    settle(2);
    c4 = done_cnt4;
    @(negedge clk);
    address = 10'd1; mem_write = 1'b0; waring4 = 1'b1;
    @(negedge clk);
    waring4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (done4 !== 1'b0 || read_value4 !== '0) begin
      failures++;
      $display("FAIL mid_read_reset: done=%b read_value=%h, required 0/0", done4, read_value4);
    end
    settle(8);
    checks++;
    if (done_cnt4 != c4) begin
      failures++;
      $display("FAIL mid_read_abandoned: pulses=%0d, required 0", done_cnt4 - c4);
    end
    read4_wait(10'd1, "reread_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] seq [3];
    logic [DW-1:0] exp;
    seq = '{10'd0, 10'd1, 10'd3};
    @(negedge clk);
    mem_write = 1'b0; waring1 = 1'b1; address = seq[0];
    exp_q1.push_back(model[seq[0]]);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      exp = exp_q1.pop_front();
      checks++;
      if (done1 !== 1'b1 || read_value1 !== exp) begin
        failures++;
        $display("FAIL b2b_%0d: done=%b read_value=%h, required 1/%h", i - 1, done1, read_value1, exp);
      end
      if (i < 3) begin
        address = seq[i];
        exp_q1.push_back(model[seq[i]]);
      end else begin
        waring1 = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: done=%b, required 0", done1);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) model[i] = '0;
    rst = 1'b1; data_in = '0; address = '0; mem_write = 1'b0;
    waring1 = 1'b0; waring4 = 1'b0;
    test_reset();
    test_seq_writes();
    test_latency();
    test_collision();
    test_reset_mid_read();
    test_back_to_back();
    settle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/main_memory.md
Name: main_memory

Overview:
- Word-addressed backing RAM: 2^ADDR_WIDTH words of DATA_WIDTH bits. It sits below the cache/datapath in the RISC-V core.
- Writes complete in a single cycle.
- Reads are requested with `waring` and return after a programmable READ_LATENCY. Completion is flagged by a one-cycle `done` pulse with `read_value` valid.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 10, word-address width; depth = 2^ADDR_WIDTH = 1024 words.
- READ_LATENCY, 1, clock edges from an accepted read request to the `done` pulse; legal range is 1..15.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- rst  input  1  reset.
- data_in  input  DATA_WIDTH  write data.
- address  input  ADDR_WIDTH  word address, for both writes and read requests.
- mem_write  input  1  write enable; level-sensitive and sampled every edge.
- waring  input  1  read request; level-sensitive and sampled every edge.
- done  output  1  read complete; one-cycle pulse.
- read_value  output  DATA_WIDTH  read data; valid while `done`=1 and held afterwards.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Storage:
  - Array of 2^ADDR_WIDTH x DATA_WIDTH words, word-addressed; `address` is not a byte address.
  - Array is initialised to all zeros at time 0.
  - `rst` does NOT clear the array.
- Reset (rst=1 at a rising edge):
  - FSM goes to IDLE, latency counter clears to 0.
  - `done`=0, `read_value`=0.
  - Any in-flight read is abandoned; no `done` pulse is issued for it.
  - A write presented in the same cycle as rst=1 is NOT performed.
- Write:
  - At a rising edge with rst=0 and mem_write=1, mem[address] <= data_in.
  - Writes are accepted in any FSM state.
  - Back-to-back writes to different addresses on consecutive cycles must all land.
- Read request acceptance:
  - Accepted at a rising edge when rst=0, waring=1, mem_write=0, and the FSM is IDLE or in its DONE cycle.
  - `address` is captured into an internal register at acceptance.
- Simultaneous mem_write=1 and waring=1: the write is performed and the read request is ignored that cycle. No `done` pulse results.
- FSM states:
  - IDLE: waits for a request. If READ_LATENCY=1, it goes directly to DONE; otherwise it goes to BUSY with counter=1.
  - BUSY: counter increments each edge. When counter reaches READ_LATENCY-1, the next edge goes to DONE. `waring` is ignored while BUSY.
  - DONE: lasts one cycle. Outputs `done`=1 and `read_value`=mem[captured address], evaluated at the entry edge of DONE. The next state is IDLE, unless a new request is accepted in this cycle, in which case the FSM follows the IDLE-acceptance rules.
- Timing:
  - A request accepted at edge N gives `done`=1 during the cycle following edge N+READ_LATENCY-1.
  - With the default READ_LATENCY=1, data is available in the cycle after the request edge.
- Read data content:
  - Read data reflects any write to the same address performed at or before the DONE entry edge.
  - A write at the DONE entry edge is read-before-write: the old value is returned.
- `read_value` holds its last returned value until the next `done` or reset.
- `done` is never high for two consecutive cycles for the same request.
- No out-of-range addressing is possible; the full address space is implemented.

Test Plan:
- Reset: assert rst for 2 cycles with waring=1 -> `done`=0 and `read_value`=0 throughout; no `done` pulse after release if waring is dropped.
- Sequential writes: mem_write=1 for 5 consecutive cycles writing addr 0/1/3/4/5 = 50/60/70/80/90. Then waring=1, mem_write=0, addr 3 for one cycle -> next cycle `done`=1 and `read_value`=70. Reading addr 0, 1, 4, 5 returns 50, 60, 80, 90; addr 2 returns 0.
- Latency: with READ_LATENCY=4, request addr 5 at edge N -> `done` low through the cycle after edge N+2 and high only in the cycle after edge N+3 with 90. `read_value` holds 90 after `done` drops.
- Collision: mem_write=1 and waring=1 together at addr 7 with data 0xDEADBEEF -> no `done`. A subsequent read of addr 7 returns 0xDEADBEEF.
- Reset mid-read: READ_LATENCY=4, request addr 1, assert rst two edges later -> no `done`, `read_value`=0. A re-read after reset returns 60 (array retained).
- Back-to-back reads: READ_LATENCY=1, waring held high with address 0, 1, 3 on consecutive cycles -> `done` high each following cycle with 50, 60, 70 in order.
